// File: rtl/segment_scroll_ctrl_if.sv
// Control, write-port and display signals of segment_scroll_ctrl.
// The master side drives the pulses and the buffer writes; the slave side is the controller.
interface segment_scroll_ctrl_if #(
  parameter int MSG_LEN = 8
);
  localparam int AW = $clog2(MSG_LEN);

  logic          i_Start;
  logic          i_Stop;
  logic          i_Pause_Toggle;
  logic          i_Step;
  logic [AW:0]   i_Len;
  logic          i_Wr_En;
  logic [AW-1:0] i_Wr_Addr;
  logic [7:0]    i_Wr_Char;
  logic [7:0]    o_Char_Left;
  logic [7:0]    o_Char_Right;
  logic          o_Busy;
  logic          o_Wrap;

  modport master (
    output i_Start, i_Stop, i_Pause_Toggle, i_Step, i_Len,
           i_Wr_En, i_Wr_Addr, i_Wr_Char,
    input  o_Char_Left, o_Char_Right, o_Busy, o_Wrap
  );

  modport slave (
    input  i_Start, i_Stop, i_Pause_Toggle, i_Step, i_Len,
           i_Wr_En, i_Wr_Addr, i_Wr_Char,
    output o_Char_Left, o_Char_Right, o_Busy, o_Wrap
  );
endinterface

// File: rtl/segment_scroll_ctrl.sv
// Scrolls a buffered ASCII message across two seven-segment digits.
// Optional SCROLL_BLANK_GAP_EN adds a virtual blank after the message before it wraps.
//
//   state    | meaning
//   ST_IDLE  | outputs blank, buffer writable, waiting for start
//   ST_RUN   | tick counter running, auto-advance at terminal count
//   ST_PAUSE | counter frozen, manual step pulses advance the window
module segment_scroll_ctrl #(
  parameter int CLKS_PER_STEP = 25000000,
  parameter int MSG_LEN       = 8
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  segment_scroll_ctrl_if.slave bus
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int PW = AW + 2;
  localparam int CW = $clog2(CLKS_PER_STEP);
  localparam logic [CW-1:0] TC    = CW'(CLKS_PER_STEP - 1);
  localparam logic [7:0]    BLANK = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_p;
  logic [LW-1:0] r_len;
  logic [7:0]    r_buf [MSG_LEN];
  logic [7:0]    r_left, r_right;
  logic          r_wrap;

  logic          w_start, w_advance, w_cnt_inc, w_cnt_clr;
  logic [LW-1:0] w_len_sample;
  logic [PW-1:0] w_len_eff, w_p_adv;
  logic          w_last;
  logic [7:0]    w_char_l, w_char_r;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Pulse priority: stop, start (idle), pause toggle, step (pause), tick (run).
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_advance = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    if (bus.i_Stop) begin
      w_next    = ST_IDLE;
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_Start) begin
            w_next    = ST_RUN;
            w_start   = 1'b1;
            w_cnt_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_Pause_Toggle) begin
            w_next = ST_PAUSE;
          end else if (r_cnt == TC) begin
            w_advance = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.i_Pause_Toggle) w_next = ST_RUN;
          else if (bus.i_Step)    w_advance = 1'b1;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (bus.i_Len == '0)                 w_len_sample = LW'(1);
    else if (bus.i_Len > LW'(MSG_LEN))   w_len_sample = LW'(MSG_LEN);
    else                                 w_len_sample = bus.i_Len;
  end

`ifdef SCROLL_BLANK_GAP_EN
  assign w_len_eff = PW'(r_len) + PW'(1);
`else
  assign w_len_eff = PW'(r_len);
`endif

  assign w_last  = (r_p == (w_len_eff - PW'(1)));
  assign w_p_adv = w_last ? '0 : (r_p + PW'(1));

  // Index L only exists as the virtual blank of the gap build.
  assign w_char_l = (r_p >= PW'(r_len))     ? BLANK : r_buf[r_p[AW-1:0]];
  assign w_char_r = (w_p_adv >= PW'(r_len)) ? BLANK : r_buf[w_p_adv[AW-1:0]];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_len   <= LW'(1);
      r_wrap  <= 1'b0;
      r_left  <= BLANK;
      r_right <= BLANK;
      for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= BLANK;
    end else begin
      r_wrap <= 1'b0;
      if (bus.i_Wr_En && (r_state == ST_IDLE)) r_buf[bus.i_Wr_Addr] <= bus.i_Wr_Char;

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);

      if (w_start) begin
        r_p   <= '0;
        r_len <= w_len_sample;
      end else if (w_advance) begin
        r_p    <= w_p_adv;
        r_wrap <= w_last;
      end

      r_left  <= (r_state == ST_IDLE) ? BLANK : w_char_l;
      r_right <= (r_state == ST_IDLE) ? BLANK : w_char_r;
    end
  end

  assign bus.o_Char_Left  = r_left;
  assign bus.o_Char_Right = r_right;
  assign bus.o_Busy       = (r_state != ST_IDLE);
  assign bus.o_Wrap       = r_wrap;
endmodule

// File: tb/tb_segment_scroll_ctrl.sv
// Directed bench for segment_scroll_ctrl with CLKS_PER_STEP=4, MSG_LEN=8.
module tb_segment_scroll_ctrl;
`ifdef SCROLL_BLANK_GAP_EN
  localparam bit GAP = 1'b1;
  localparam int NWIN = 6;
  string win_l = "ELLO H";
  string win_r = "LLO HE";
`else
  localparam bit GAP = 1'b0;
  localparam int NWIN = 5;
  string win_l = "ELLOH";
  string win_r = "LLOHE";
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  string hello = "HELLO";

  always #5 clk = ~clk;

  segment_scroll_ctrl_if #(.MSG_LEN(8)) bus ();

  segment_scroll_ctrl #(.CLKS_PER_STEP(4), .MSG_LEN(8)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [7:0] l, input logic [7:0] r);
    chk({tag, "_left"}, bus.o_Char_Left, l);
    chk({tag, "_right"}, bus.o_Char_Right, r);
  endtask

  task automatic wr(input int a, input logic [7:0] c);
    bus.i_Wr_En = 1'b1; bus.i_Wr_Addr = 3'(a); bus.i_Wr_Char = c;
    tick();
    bus.i_Wr_En = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    bus.i_Len = 4'(len); bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
  endtask

  task automatic pulse_toggle();
    bus.i_Pause_Toggle = 1'b1; tick(); bus.i_Pause_Toggle = 1'b0;
  endtask

  task automatic pulse_step();
    bus.i_Step = 1'b1; tick(); bus.i_Step = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_Stop = 1'b1; tick(); bus.i_Stop = 1'b0;
  endtask

  initial begin
    bus.i_Start = 1'b0; bus.i_Stop = 1'b0; bus.i_Pause_Toggle = 1'b0; bus.i_Step = 1'b0;
    bus.i_Len = '0; bus.i_Wr_En = 1'b0; bus.i_Wr_Addr = '0; bus.i_Wr_Char = '0;
    tick(2);
    rst = 1'b0;
    tick();
    chk_win("reset", 8'h20, 8'h20);
    chk("reset_busy", 8'(bus.o_Busy), 8'h00);
    chk("reset_wrap", 8'(bus.o_Wrap), 8'h00);

    for (int i = 0; i < 5; i++) wr(i, hello[i]);

    // Start at edge S; busy now, window one edge later.
    pulse_start(5);
    chk("start_busy", 8'(bus.o_Busy), 8'h01);
    chk("start_latency_left", bus.o_Char_Left, 8'h20);
    tick();
    chk_win("start_win", "H", "E");
    for (int k = 1; k <= NWIN; k++) begin
      tick(3);
      chk($sformatf("run_wrap%0d", k), 8'(bus.o_Wrap), (k == NWIN) ? 8'h01 : 8'h00);
      tick();
      chk_win($sformatf("run_win%0d", k), win_l[k-1], win_r[k-1]);
    end

    // Counter is at 1; pause once it holds 2, resume must advance 2 edges later.
    tick();
    pulse_toggle();
    chk("pause_busy", 8'(bus.o_Busy), 8'h01);
    tick(10);
    chk_win("pause_hold", "H", "E");
    pulse_toggle();
    tick();
    chk("resume_wrap", 8'(bus.o_Wrap), 8'h00);
    chk_win("resume_r1", "H", "E");
    tick();
    chk_win("resume_r2", "H", "E");
    tick();
    chk_win("resume_r3", "E", "L");

    pulse_toggle();
    pulse_step();
    pulse_step();
    tick();
    chk_win("two_steps", "L", "O");
    pulse_toggle();
    pulse_step();
    tick();
    chk_win("step_in_run", "L", "O");

    wr(0, "Z");
    pulse_stop();
    chk("stop_busy", 8'(bus.o_Busy), 8'h00);
    tick();
    chk_win("stop_blank", 8'h20, 8'h20);
    pulse_start(5);
    tick();
    chk_win("busy_write_ignored", "H", "E");

    pulse_stop();
    pulse_start(0);
    tick();
    chk_win("len0_win", "H", GAP ? 8'h20 : "H");
    tick(2);
    chk("len0_wrap_s3", 8'(bus.o_Wrap), 8'h00);
    tick();
    chk("len0_wrap_s4", 8'(bus.o_Wrap), GAP ? 8'h00 : 8'h01);
    tick();
    chk("len0_wrap_s5", 8'(bus.o_Wrap), 8'h00);
    chk_win("len0_win_s5", GAP ? 8'h20 : "H", "H");
    tick(3);
    chk("len0_wrap_s8", 8'(bus.o_Wrap), 8'h01);

    pulse_stop();
    wr(5, "1"); wr(6, "2"); wr(7, "3");
    pulse_start(12);
    pulse_toggle();
    bus.i_Step = 1'b1;
    tick(7);
    bus.i_Step = 1'b0;
    tick();
    chk_win("clamp_p7", "3", GAP ? 8'h20 : "H");
    pulse_step();
    chk("clamp_wrap", 8'(bus.o_Wrap), GAP ? 8'h00 : 8'h01);
    tick();
    chk_win("clamp_after", GAP ? 8'h20 : "H", GAP ? "H" : "E");

    bus.i_Stop = 1'b1; bus.i_Pause_Toggle = 1'b1;
    tick();
    bus.i_Stop = 1'b0; bus.i_Pause_Toggle = 1'b0;
    chk("stop_toggle_busy", 8'(bus.o_Busy), 8'h00);
    tick();
    chk_win("stop_toggle_blank", 8'h20, 8'h20);

    wr(0, "H"); wr(1, "I");
    pulse_start(2);
    tick();
    chk_win("hi_win1", "H", "I");
    pulse_toggle();
    pulse_step();
    tick();
    chk_win("hi_win2", "I", GAP ? 8'h20 : "H");
    pulse_step();
    tick();
    chk_win("hi_win3", GAP ? 8'h20 : "H", GAP ? "H" : "I");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/segment_scroll_ctrl.md
# segment_scroll_ctrl

Sequencer that scrolls a short ASCII message across the board's two seven-segment digits. It holds a small character buffer loaded over a simple write port and steps a window position at a fixed tick rate or on manual step pulses. Its two 8-bit character outputs feed the per-digit character-to-segment decoders. Its start, stop, pause and step inputs are single-cycle pulses, produced upstream by debounced switch edge detectors.

## Interface

Parameters:
- CLKS_PER_STEP, 25000000, clocks per automatic scroll step (1 s at 25 MHz); minimum 2
- MSG_LEN, 8, buffer depth in characters; power of two, 2..16

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_Start  in  1  pulse; IDLE -> RUN
- i_Stop  in  1  pulse; any state -> IDLE
- i_Pause_Toggle  in  1  pulse; RUN <-> PAUSE
- i_Step  in  1  pulse; advance one position, honoured in PAUSE only
- i_Len  in  clog2(MSG_LEN)+1  active message length, sampled on accepted start
- i_Wr_En  in  1  buffer write strobe
- i_Wr_Addr  in  clog2(MSG_LEN)  buffer index
- i_Wr_Char  in  8  ASCII character
- o_Char_Left  out  8  character for digit 1
- o_Char_Right  out  8  character for digit 2
- o_Busy  out  1  high when state is not IDLE
- o_Wrap  out  1  one-cycle pulse when position wraps to 0

## Operation

- States: IDLE, RUN, PAUSE.
  - IDLE -> RUN on i_Start.
  - RUN <-> PAUSE on i_Pause_Toggle.
  - RUN/PAUSE -> IDLE on i_Stop.
- Pulse priority per cycle: i_Stop > i_Start (IDLE only) > i_Pause_Toggle > i_Step > tick. Lower-priority pulses in the same cycle are discarded.
- i_Start is ignored outside IDLE.
- i_Step is ignored in RUN and IDLE.
- Buffer writes are accepted only in IDLE; i_Wr_En is ignored when o_Busy=1. There is no ack.
- Length L, latched on start:
  - i_Len=0 is treated as 1.
  - i_Len>MSG_LEN is clamped to MSG_LEN.
  - L is held until the next start.
- Position p ranges 0..L-1 and is set to 0 on start.
- Advance rule: p <= (p==L-1) ? 0 : p+1. o_Wrap pulses on the L-1 -> 0 transition.
- Display window: o_Char_Left = buf[p], o_Char_Right = buf[(p+1) mod L]. For L=1, both digits show buf[0].
- In IDLE, both outputs are 0x20 (blank).
- Tick counter:
  - runs 0..CLKS_PER_STEP-1 in RUN only; the terminal count advances p and reloads 0;
  - holds its value in PAUSE, so resume continues the partial interval;
  - is cleared on start, stop and reset.
- Reset: state IDLE, p=0, L=1, counter 0, all buffer entries 0x20, o_Char_Left=o_Char_Right=0x20, o_Busy=0, o_Wrap=0.

## Timing

- All outputs are registered.
- Character outputs reflect state, p and buffer contents as of the previous edge: 1-cycle latency.
- Start accepted at edge N: o_Busy=1 and counter=0 after edge N; outputs show buf[0]/buf[1] after edge N+1.
- RUN: the first automatic advance occurs CLKS_PER_STEP cycles after the start edge, then every CLKS_PER_STEP cycles.
- Step in PAUSE at edge N: p updates at N, outputs at N+1.
- o_Wrap asserts in the same cycle as the p update.
- Stop at edge N: o_Busy=0 after N; outputs blank after N+1.
- Write and start in the same IDLE cycle: the write commits at that edge and is visible in the first displayed window.
- Reset mid-operation overrides everything at the next edge.

## Configuration

- SCROLL_BLANK_GAP_EN defined: the effective length is L+1, with a virtual 0x20 character at index L. The message scrolls off with a blank separator. o_Wrap fires on the L -> 0 transition.
- Not defined: the effective length is L and the message wraps seamlessly.

## Test plan

Bench uses CLKS_PER_STEP=4, MSG_LEN=8.

- Reset -> o_Char_Left=o_Char_Right=0x20, o_Busy=0, o_Wrap=0; writes of "HELLO" to addr 0..4 accepted.
- Load "HELLO", i_Len=5, i_Start -> outputs "H","E"; then every 4 cycles "E","L" / "L","L" / "L","O" / "O","H" (gap macro off); o_Wrap pulses on the return to "H","E".
- i_Pause_Toggle after 2 RUN cycles; 10 idle cycles; toggle again -> next advance exactly 2 cycles later. Two i_Step pulses in PAUSE -> p advances by 2; i_Step in RUN -> no change.
- i_Wr_En while busy to addr 0 with "Z" -> buffer unchanged; after i_Stop and restart, the display still shows "H".
- i_Len=0 -> both digits show buf[0]; o_Wrap pulses every 4 cycles. i_Len=12 -> length clamped to 8.
- i_Stop and i_Pause_Toggle in the same cycle -> IDLE, outputs blank. With SCROLL_BLANK_GAP_EN and "HI", L=2 -> window sequence "H","I" / "I"," " / " ","H".
